// File: rtl/midi_note_tx.sv
// midi_note_tx: turns a one-hot key request plus program number into MIDI Note On/Off
// and Program Change messages on an 8N1 UART line.
module midi_note_tx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 31250,
  parameter int CHANNEL   = 0,
  parameter int BASE_NOTE = 60,
  parameter int VELOCITY  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] note,
  input  logic [4:0] pitchshift,
  input  logic       on_value,
  input  logic [6:0] program_num,
  output logic       tx,
  output logic       busy
);
  localparam int BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(BIT + 1);
  typedef enum logic [1:0] {IDLE, PROG, OFF, ON} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d, last_q, last_d;
  logic [23:0] msg_q, msg_d;
  logic tx_q, tx_d, busy_q, busy_d, sounding_q, sounding_d;
  logic [6:0] skey_q, skey_d, lprog_q, lprog_d;
  logic [3:0] idx;
  logic signed [9:0] key_raw;
  logic [6:0] key;
  logic req;
  logic [7:0] cur;
  logic [9:0] frame;
  always_comb begin
    idx = '0;
    for (int i = 9; i >= 0; i--) if (note[i]) idx = 4'(i);
    key_raw = 10'(BASE_NOTE) + 10'(idx) + 10'(pitchshift) - 10'sd12;
    key = (key_raw < 10'sd0) ? 7'd0 : (key_raw > 10'sd127) ? 7'd127 : key_raw[6:0];
    req = on_value && (|note);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    byte_d = byte_q;
    last_d = last_q;
    msg_d = msg_q;
    sounding_d = sounding_q;
    skey_d = skey_q;
    lprog_d = lprog_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      bit_d = '0;
      byte_d = '0;
      if (program_num != lprog_q) begin
        state_d = PROG;
        msg_d = {8'h00, 1'b0, program_num, 4'hC, 4'(CHANNEL)};
        last_d = 2'd1;
        lprog_d = program_num;
      end else if (sounding_q && (!req || key != skey_q)) begin
        state_d = OFF;
        msg_d = {8'h00, 1'b0, skey_q, 4'h8, 4'(CHANNEL)};
        last_d = 2'd2;
      end else if (!sounding_q && req) begin
        state_d = ON;
        msg_d = {8'(VELOCITY), 1'b0, key, 4'h9, 4'(CHANNEL)};
        last_d = 2'd2;
      end
    end else if (cnt_q == CW'(BIT - 1)) begin
      cnt_d = '0;
      if (bit_q != 4'd9) bit_d = bit_q + 4'd1;
      else if (byte_q != last_q) begin
        bit_d = '0;
        byte_d = byte_q + 2'd1;
      end else begin
        state_d = IDLE;
        sounding_d = (state_q == ON) ? 1'b1 : (state_q == OFF) ? 1'b0 : sounding_q;
        skey_d = (state_q == ON) ? msg_q[14:8] : skey_q;
      end
    end else cnt_d = CW'(cnt_q + 1'b1);
    // tx/busy are registered, so they follow the next-state bit position
    busy_d = state_d != IDLE;
    cur = (byte_d == 2'd0) ? msg_d[7:0] : (byte_d == 2'd1) ? msg_d[15:8] : msg_d[23:16];
    frame = {1'b1, cur, 1'b0};
    tx_d = busy_d ? frame[bit_d] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      last_q <= '0;
      msg_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      sounding_q <= 1'b0;
      skey_q <= '0;
      lprog_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      last_q <= last_d;
      msg_q <= msg_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      sounding_q <= sounding_d;
      skey_q <= skey_d;
      lprog_q <= lprog_d;
    end
  end
  assign tx = tx_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_midi_note_tx.sv
// tb_midi_note_tx: three instances (BASE_NOTE 60/120/0) share inputs; a UART receiver per
// instance collects bytes, compared against table vectors and a message-level model.
module tb_midi_note_tx;
  localparam int BIT = 16;
  logic clk = 0;
  logic rst = 1;
  logic [9:0] note = '0;
  logic [4:0] ps = 5'd12;
  logic on_v = 1'b1;
  logic [6:0] prog = '0;
  logic [2:0] tx_w, busy_w;
  int checks = 0, fails = 0, busy_cnt = 0;
  int rxq[$];
  int expq[$];
  int base[3] = '{60, 120, 0};
  bit msnd[3];
  int mkey[3], mprog[3];

  always #5 clk = ~clk;

  midi_note_tx #(.CLK_FREQ(160), .BAUD(10), .BASE_NOTE(60)) u0 (.clk(clk), .rst(rst), .note(note),
    .pitchshift(ps), .on_value(on_v), .program_num(prog), .tx(tx_w[0]), .busy(busy_w[0]));
  midi_note_tx #(.CLK_FREQ(160), .BAUD(10), .BASE_NOTE(120)) u1 (.clk(clk), .rst(rst), .note(note),
    .pitchshift(ps), .on_value(on_v), .program_num(prog), .tx(tx_w[1]), .busy(busy_w[1]));
  midi_note_tx #(.CLK_FREQ(160), .BAUD(10), .BASE_NOTE(0)) u2 (.clk(clk), .rst(rst), .note(note),
    .pitchshift(ps), .on_value(on_v), .program_num(prog), .tx(tx_w[2]), .busy(busy_w[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver: samples mid-bit; a frame cut short by reset or busy dropping is discarded.
  for (genvar g = 0; g < 3; g++) begin : rx
    always begin : dec
      logic [9:0] fr;
      logic ab;
      @(negedge clk);
      if (!rst && !tx_w[g]) begin
        fr = '0;
        ab = 1'b0;
        for (int n = 1; n <= BIT / 2 + 9 * BIT; n++) begin
          @(negedge clk);
          if (!busy_w[g] || rst) begin
            ab = 1'b1;
            break;
          end
          if (n >= BIT / 2 && (n - BIT / 2) % BIT == 0) fr[(n - BIT / 2) / BIT] = tx_w[g];
        end
        if (!ab) begin
          chk($sformatf("framing dut%0d", g), {30'd0, fr[9], fr[0]}, 2);
          rxq.push_back(g * 256 + int'(fr[8:1]));
        end
      end
    end
  end

  function automatic int keyof(input int g);
    int idx = 0, k;
    for (int i = 0; i < 10; i++) if (note[i]) begin
      idx = i;
      break;
    end
    k = base[g] + idx + int'(ps) - 12;
    return k < 0 ? 0 : k > 127 ? 127 : k;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      msnd[g] = 0;
      mkey[g] = 0;
      mprog[g] = 0;
    end
  endtask

  task automatic model_run(input int g);
    bit req;
    int k;
    expq.delete();
    for (int guard = 0; guard < 4; guard++) begin
      req = on_v && note != 0;
      k = keyof(g);
      if (int'(prog) != mprog[g]) begin
        expq.push_back(8'hC0); expq.push_back(int'(prog)); mprog[g] = int'(prog);
      end else if (msnd[g] && (!req || k != mkey[g])) begin
        expq.push_back(8'h80); expq.push_back(mkey[g]); expq.push_back(0); msnd[g] = 0;
      end else if (!msnd[g] && req) begin
        expq.push_back(8'h90); expq.push_back(k); expq.push_back(100); msnd[g] = 1; mkey[g] = k;
      end else break;
    end
  endtask

  task automatic check_dut(input int g, input string name);
    int got[$];
    foreach (rxq[i]) if ((rxq[i] >> 8) == g) got.push_back(rxq[i] & 255);
    chk($sformatf("%s dut%0d byte count", name, g), got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk($sformatf("%s dut%0d byte%0d", name, g, i), got[i], expq[i]);
  endtask

  task automatic settle();
    int quiet = 0, cyc = 0;
    busy_cnt = 0;
    while (quiet < 4 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      quiet = (busy_w == 3'b000) ? quiet + 1 : 0;
      if (busy_w[0]) busy_cnt++;
    end
    if (cyc >= 20000) chk("settle timeout", cyc, 0);
  endtask

  typedef struct packed {
    logic [9:0] note;
    logic [4:0] ps;
    logic on;
    logic [6:0] prog;
    logic [2:0][3:0] n;
    logic [2:0][47:0] b;
  } vec_t;

  vec_t tv[12];

  function automatic vec_t mk(input logic [9:0] nt, input logic [4:0] p, input logic o,
                              input logic [6:0] pr, input logic [3:0] n0, input logic [47:0] b0,
                              input logic [3:0] n1, input logic [47:0] b1,
                              input logic [3:0] n2, input logic [47:0] b2);
    vec_t v;
    v.note = nt; v.ps = p; v.on = o; v.prog = pr;
    v.n[0] = n0; v.n[1] = n1; v.n[2] = n2;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
    return v;
  endfunction

  task automatic load_exp(input vec_t v, input int g);
    logic [47:0] bb;
    bb = v.b[g];
    expq.delete();
    for (int i = 0; i < int'(v.n[g]); i++) expq.push_back(int'(bb[47 - 8 * i -: 8]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0]  = mk(10'h000, 12, 1, 0, 0, 48'h0, 0, 48'h0, 0, 48'h0);
    tv[1]  = mk(10'h004, 12, 1, 0, 3, 48'h903E64000000, 3, 48'h907A64000000, 3, 48'h900264000000);
    tv[2]  = mk(10'h008, 12, 1, 0, 6, 48'h803E00903F64, 6, 48'h807A00907B64, 6, 48'h800200900364);
    tv[3]  = mk(10'h008, 12, 1, 5, 2, 48'hC00500000000, 2, 48'hC00500000000, 2, 48'hC00500000000);
    tv[4]  = mk(10'h000, 12, 1, 5, 3, 48'h803F00000000, 3, 48'h807B00000000, 3, 48'h800300000000);
    tv[5]  = mk(10'h200, 31, 1, 5, 3, 48'h905864000000, 3, 48'h907F64000000, 3, 48'h901C64000000);
    tv[6]  = mk(10'h001, 0, 1, 5, 6, 48'h805800903064, 6, 48'h807F00906C64, 6, 48'h801C00900064);
    tv[7]  = mk(10'h001, 0, 0, 5, 3, 48'h803000000000, 3, 48'h806C00000000, 3, 48'h800000000000);
    tv[8]  = mk(10'h301, 0, 1, 5, 3, 48'h903064000000, 3, 48'h906C64000000, 3, 48'h900064000000);
    tv[9]  = mk(10'h300, 0, 1, 5, 6, 48'h803000903864, 6, 48'h806C00907464, 0, 48'h0);
    tv[10] = mk(10'h300, 0, 1, 5, 0, 48'h0, 0, 48'h0, 0, 48'h0);
    tv[11] = mk(10'h000, 0, 1, 0, 5, 48'hC00080380000, 5, 48'hC00080740000, 5, 48'hC00080000000);

    repeat (3) @(negedge clk);
    chk("reset tx", int'(tx_w), 7);
    chk("reset busy", int'(busy_w), 0);
    rst = 0;
    model_reset();
    repeat (200) begin
      @(negedge clk);
      if (tx_w != 3'b111 || busy_w != 3'b000) break;
    end
    chk("idle tx after reset", int'(tx_w), 7);
    chk("idle busy after reset", int'(busy_w), 0);

    for (int r = 0; r < 12; r++) begin
      note = tv[r].note; ps = tv[r].ps; on_v = tv[r].on; prog = tv[r].prog;
      settle();
      chk($sformatf("row%0d busy cycles", r), busy_cnt, int'(tv[r].n[0]) * 10 * BIT);
      for (int g = 0; g < 3; g++) begin
        model_run(g);
        load_exp(tv[r], g);
        check_dut(g, $sformatf("row%0d", r));
      end
      rxq.delete();
    end

    // reset mid data bit 4 of the first byte: frame abandoned, message resent
    note = 10'h004; ps = 12; on_v = 1; prog = 0;
    repeat (5 * BIT + BIT / 2) @(negedge clk);
    chk("busy before mid-byte reset", int'(busy_w), 7);
    rst = 1;
    @(negedge clk);
    chk("tx after mid-byte reset", int'(tx_w), 7);
    chk("busy after mid-byte reset", int'(busy_w), 0);
    rst = 0;
    model_reset();
    settle();
    for (int g = 0; g < 3; g++) begin
      model_run(g);
      check_dut(g, "resend");
    end
    rxq.delete();

    // inputs toggled during a message are not queued; only IDLE-time values count
    note = 10'h008;
    repeat (20) @(negedge clk);
    prog = 9; note = 10'h004;
    repeat (20) @(negedge clk);
    prog = 0;
    settle();
    for (int g = 0; g < 3; g++) begin
      expq = '{8'h80, 0, 0, 8'h90, 0, 100};
      expq[1] = mkey[g];
      expq[4] = mkey[g];
      check_dut(g, "no-queue");
    end
    rxq.delete();

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0: note = '0;
        1, 2: note = 10'(1) << $urandom_range(0, 9);
        default: note = 10'($urandom_range(0, 1023));
      endcase
      ps = 5'($urandom_range(0, 31));
      on_v = $urandom_range(0, 5) != 0;
      if ($urandom_range(0, 3) == 0) prog = 7'($urandom_range(0, 127));
      settle();
      for (int g = 0; g < 3; g++) begin
        model_run(g);
        check_dut(g, $sformatf("rand%0d", it));
      end
      rxq.delete();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/midi_note_tx.md
MIDI_NOTE_TX -- requirements
Module: midi_note_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, serial bit rate; bit period = CLK_FREQ/BAUD cycles (3200 at defaults).
REQ-003 SHALL have parameter CHANNEL, default 0, MIDI channel 0..15 in the status-byte low nibble.
REQ-004 SHALL have parameter BASE_NOTE, default 60, MIDI key for note[0] at zero shift.
REQ-005 SHALL have parameter VELOCITY, default 100 (0x64), Note On velocity.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port note, input, 10, one-hot key request; all-zero means no key.
REQ-009 SHALL have port pitchshift, input, 5, unsigned; semitone offset = pitchshift - 12.
REQ-010 SHALL have port on_value, input, 1, note enable; low forces silence.
REQ-011 SHALL have port program, input, 7, requested MIDI program number.
REQ-012 SHALL have port tx, output, 1, UART serial line, idle high.
REQ-013 SHALL have port busy, output, 1, high while a message is being transmitted.

Function
REQ-014 Key computation SHALL be: BASE_NOTE + index of the lowest set bit of note + pitchshift - 12, in signed arithmetic at least 9 bits wide, clamped to 0..127.
REQ-015 Multiple set bits SHALL resolve to the lowest index; note==0 or on_value==0 SHALL mean "no key requested".
REQ-016 Internal state SHALL hold sounding (1 bit), sounding_key (7 bits), and last_program (7 bits).
REQ-017 FSM states SHALL be IDLE, PROG, OFF, ON; inputs SHALL be evaluated only in IDLE.
REQ-018 IDLE priority 1: if program != last_program, go to PROG, send 0xC0|CHANNEL then program, and latch last_program at message start.
REQ-019 IDLE priority 2: if sounding and (no key requested or computed key != sounding_key), go to OFF and send 0x80|CHANNEL, sounding_key, 0x00; then clear sounding.
REQ-020 IDLE priority 3: if not sounding and a key is requested, go to ON and send 0x90|CHANNEL, key, VELOCITY; then set sounding and sounding_key; key is latched at message start.
REQ-021 A key change SHALL therefore produce OFF then ON back to back, with IDLE re-evaluation between the two messages.
REQ-022 Input changes during a message SHALL NOT be queued; only the input values present at the next IDLE evaluation matter.
REQ-023 Each byte SHALL be sent as 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each exactly CLK_FREQ/BAUD cycles; bytes of one message SHALL be contiguous with no idle gap.
REQ-024 busy SHALL rise the cycle after IDLE leaves and fall the cycle after the last stop bit ends.
REQ-025 tx SHALL be 1 whenever no start, data, or stop bit is being driven.
REQ-026 Unchanged inputs SHALL generate no traffic: no repeated Note On and no running-status compression.

Reset
REQ-027 In any cycle with rst high, tx SHALL become 1, busy 0, FSM IDLE, bit/baud counters 0, sounding 0, sounding_key 0, and last_program 0 on the next edge.
REQ-028 rst SHALL override everything, including mid-byte; the partial frame SHALL be abandoned and no Note Off issued (a stuck remote note is accepted).
REQ-029 After reset, program==0 SHALL produce no program-change message.

Verification (defaults, 3200 cycles/bit, 32000 cycles/byte)
REQ-030 Reset, note=0, program=0, on_value=1 for 100000 cycles -> tx constant 1, busy 0.
REQ-031 note=10'b0000000100, pitchshift=12 -> bytes 0x90, 0x3E, 0x64; busy high for exactly 96000 cycles.
REQ-032 Then note=10'b0000001000 -> 0x80, 0x3E, 0x00, 0x90, 0x3F, 0x64.
REQ-033 Key held, program 0->5 -> 0xC0, 0x05 only; then note=0 -> 0x80, 0x3F, 0x00.
REQ-034 BASE_NOTE=120, note bit 9, pitchshift=31 -> key clamps to 0x7F; BASE_NOTE=0, note bit 0, pitchshift=0 -> key clamps to 0x00.
REQ-035 rst pulsed 1 cycle at mid data bit 4 -> tx=1 and busy=0 on the next edge; the same request resends a complete message afterwards.
